puf_eval_ctrl: RTL

Clocked controller that sequences a bank of latch-based one-bit PUF cells through repeated clear/arm/run/sample evaluations and majority-votes the per-cell results into a stable response word. It owns the shared `START` and `reset` nets of the PUF bank and synchronizes the cells' asynchronous outputs. It also flags cells whose votes disagree, so the key-generation logic above it can mask unreliable bits. It sits between the PUF array and the key/ID register, and is triggered by a simple req/done handshake.

---
 rtl/puf_eval_ctrl_if.sv | 32 +++
 rtl/puf_eval_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : puf_eval_ctrl_if
// Brief    : Bundle of request/response and PUF-bank nets between the
//            evaluation controller, its requester and the PUF array.
// Revision : 1.0 - initial release
// ============================================================================
interface puf_eval_ctrl_if #(
  parameter int N_BITS = 8
);
  logic              req;
  logic [N_BITS-1:0] puf_out;
  logic              puf_reset;
  logic              puf_start;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] response;
  logic [N_BITS-1:0] unstable;

  // Requester / PUF-bank side
  modport master (
    output req, puf_out,
    input  puf_reset, puf_start, busy, done, response, unstable
  );

  // Controller side
  modport slave (
    input  req, puf_out,
    output puf_reset, puf_start, busy, done, response, unstable
  );
endinterface
`default_nettype wire

// File: rtl/puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : puf_eval_ctrl
// Brief    : Sequences a latch-based PUF bank through repeated
//            clear/arm/run/sample evaluations, majority-votes each cell and
//            flags cells whose votes were not unanimous.
// Revision : 1.0 - initial release
// ============================================================================
module puf_eval_ctrl #(
  parameter int N_BITS    = 8,
  parameter int N_EVAL    = 5,
  parameter int RESET_CYC = 4,
  parameter int SETTLE    = 10
) (
  input  logic             clk,
  input  logic             reset,
  puf_eval_ctrl_if.slave   bus
);

  localparam int c_VOTE_W  = $clog2(N_EVAL + 1);
  localparam int c_CYC_MAX = (RESET_CYC > SETTLE) ? RESET_CYC : SETTLE;
  localparam int c_CYC_W   = $clog2(c_CYC_MAX + 1);

  localparam logic [c_CYC_W-1:0]  c_CLR_LAST  = c_CYC_W'(RESET_CYC - 1);
  localparam logic [c_CYC_W-1:0]  c_RUN_LAST  = c_CYC_W'(SETTLE - 1);
  localparam logic [c_VOTE_W-1:0] c_EVAL_LAST = c_VOTE_W'(N_EVAL - 1);
  localparam logic [c_VOTE_W-1:0] c_EVAL_FULL = c_VOTE_W'(N_EVAL);
  localparam logic [c_VOTE_W-1:0] c_HALF      = c_VOTE_W'(N_EVAL / 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [c_CYC_W-1:0]  r_cyc;
  logic [c_VOTE_W-1:0] r_eval;
  logic [c_VOTE_W-1:0] r_vote      [N_BITS];
  logic [c_VOTE_W-1:0] w_vote_next [N_BITS];
  logic [N_BITS-1:0]   r_sync1, r_sync2;
  logic [N_BITS-1:0]   w_resp, w_unst;
  logic [N_BITS-1:0]   r_response, r_unstable;
  logic                w_last, w_accept;
  logic                w_puf_reset, w_puf_start, w_busy, w_done;
  logic                r_puf_reset, r_puf_start, r_busy, r_done;

  assign w_last   = (r_eval == c_EVAL_LAST);
  assign w_accept = (r_state == S_IDLE) && bus.req;

  // Two-flop synchronizer for the asynchronous cell outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.puf_out;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req) w_state_next = S_CLEAR;
      S_CLEAR:  if (r_cyc == c_CLR_LAST) w_state_next = S_ARM;
      S_ARM:    w_state_next = S_RUN;
      S_RUN:    if (r_cyc == c_RUN_LAST) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = w_last ? S_DONE : S_CLEAR;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with r_state
  always_comb begin
    w_puf_reset = (w_state_next == S_IDLE) || (w_state_next == S_CLEAR) ||
                  (w_state_next == S_DONE);
    w_puf_start = (w_state_next == S_RUN) || (w_state_next == S_SAMPLE);
    w_busy      = (w_state_next != S_IDLE);
    w_done      = (w_state_next == S_DONE);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_puf_reset <= 1'b1;
      r_puf_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_puf_reset <= w_puf_reset;
      r_puf_start <= w_puf_start;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Dwell counter for CLEAR and RUN; restarts on every state change
  always_ff @(posedge clk) begin
    if (reset || (w_state_next != r_state)) r_cyc <= '0;
    else if ((r_state == S_CLEAR) || (r_state == S_RUN)) r_cyc <= r_cyc + 1'b1;
  end

  // Per-cell vote arithmetic and final decision
  generate
    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
      assign w_vote_next[i] = r_vote[i] + c_VOTE_W'(r_sync2[i]);
      assign w_resp[i]      = (w_vote_next[i] > c_HALF);
      assign w_unst[i]      = (w_vote_next[i] != '0) && (w_vote_next[i] != c_EVAL_FULL);
    end
  endgenerate

  // Eval and vote counters: cleared on accept, accumulated in SAMPLE
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_eval <= '0;
      for (int i = 0; i < N_BITS; i++) r_vote[i] <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_eval <= r_eval + 1'b1;
      for (int i = 0; i < N_BITS; i++) r_vote[i] <= w_vote_next[i];
    end
  end

  // Result registers, loaded on the edge entering DONE (includes the final sample)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_response <= '0;
      r_unstable <= '0;
    end else if ((r_state == S_SAMPLE) && w_last) begin
      r_response <= w_resp;
      r_unstable <= w_unst;
    end
  end

  assign bus.puf_reset = r_puf_reset;
  assign bus.puf_start = r_puf_start;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.response  = r_response;
  assign bus.unstable  = r_unstable;

endmodule
`default_nettype wire
